// File: rtl/booth_pkg.sv
// booth_pkg: shared constants for the radix-2 Booth multiplier datapath.
//   BOOTH_N       default operand width
//   BOOTH_CW      iteration counter width derived from BOOTH_N
//   BOOTH_*       Q_LSB decision codes seen by the control FSM
//   ADD / SUB     add_sub strobe encodings
package booth_pkg;
  localparam int BOOTH_N  = 8;
  localparam int BOOTH_CW = $clog2(BOOTH_N) + 1;

  // {LQ[0], Q_1} pair: 01 -> add M, 10 -> subtract M, 00/11 -> no operation
  localparam logic [1:0] BOOTH_NOP0 = 2'b00;
  localparam logic [1:0] BOOTH_ADD  = 2'b01;
  localparam logic [1:0] BOOTH_SUB  = 2'b10;
  localparam logic [1:0] BOOTH_NOP1 = 2'b11;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;
endpackage

// File: rtl/module_booth_addsub.sv
// module_booth_addsub: combinational (N+1)-bit accumulator adder/subtractor.
//   hq      in  N+1  accumulator, including its guard bit
//   m       in  N    multiplicand, signed; sign-extended to N+1 bits here
//   add_sub in  1    ADD: hq+m, SUB: hq-m
//   sum     out N+1  result modulo 2^(N+1)
module module_booth_addsub
  import booth_pkg::*;
#(
  parameter int N = BOOTH_N
) (
  input  logic [N:0]   hq,
  input  logic [N-1:0] m,
  input  logic         add_sub,
  output logic [N:0]   sum
);
  logic [N:0] m_ext;

  assign m_ext = {m[N-1], m};
  assign sum   = (add_sub == SUB) ? (hq - m_ext) : (hq + m_ext);
endmodule

// File: rtl/module_booth_datapath.sv
// module_booth_datapath: radix-2 Booth multiplier datapath driven by the
// Booth control FSM strobes.
//   clk, rst           clock (rising edge), asynchronous active-low reset
//   load_A             capture A into M
//   load_B             capture B into LQ, clear HQ/Q_1/Y_valid, cnt=N
//   load_add, add_sub  HQ <= HQ +/- M
//   shift_HQ_LQ_Q_1    arithmetic right shift of {HQ,LQ,Q_1}, cnt decrement
//   A, B               signed operands
//   Q_LSB              {LQ[0], Q_1} decision pair for the FSM
//   z                  counter reached zero
//   Y, Y_valid         signed 2N-bit product and its completion flag
module module_booth_datapath
  import booth_pkg::*;
#(
  parameter int N  = BOOTH_N,
  parameter int CW = $clog2(N) + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_A,
  input  logic           load_B,
  input  logic           load_add,
  input  logic           add_sub,
  input  logic           shift_HQ_LQ_Q_1,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic [1:0]     Q_LSB,
  output logic           z,
  output logic [2*N-1:0] Y,
  output logic           Y_valid
);
  logic [N-1:0]  m;
  logic [N:0]    hq;   // extra guard bit keeps -2^(N-1) * -2^(N-1) exact
  logic [N-1:0]  lq;
  logic          q_1;
  logic [CW-1:0] cnt;
  logic [N:0]    sum;

  module_booth_addsub #(.N(N)) u_addsub (
    .hq      (hq),
    .m       (m),
    .add_sub (add_sub),
    .sum     (sum)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) m <= '0;
    else if (load_A) m <= A;
  end

  // load_B > load_add > shift; a losing strobe is simply dropped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hq      <= '0;
      lq      <= '0;
      q_1     <= 1'b0;
      cnt     <= '0;
      Y_valid <= 1'b0;
    end else if (load_B) begin
      hq      <= '0;
      lq      <= B;
      q_1     <= 1'b0;
      cnt     <= CW'(N);
      Y_valid <= 1'b0;
    end else if (load_add) begin
      hq <= sum;
    end else if (shift_HQ_LQ_Q_1) begin
      {hq, lq, q_1} <= {hq[N], hq, lq};
      // counter saturates at zero so stray shifts cannot restart it
      if (cnt != '0) cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) Y_valid <= 1'b1;
    end
  end

  assign Q_LSB = {lq[0], q_1};
  assign z     = (cnt == '0);
  assign Y     = {hq[N-1:0], lq};
endmodule

// File: tb/tb_module_booth_datapath.sv
module tb_module_booth_datapath;
  import booth_pkg::*;

  localparam int N = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load_A = 1'b0, load_B = 1'b0, load_add = 1'b0;
  logic          add_sub = 1'b0, shift_HQ_LQ_Q_1 = 1'b0;
  logic [N-1:0]  A = '0, B = '0;
  logic [1:0]    Q_LSB;
  logic          z;
  logic [2*N-1:0] Y;
  logic          Y_valid;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  module_booth_datapath #(.N(N)) dut (
    .clk             (clk),
    .rst             (rst),
    .load_A          (load_A),
    .load_B          (load_B),
    .load_add        (load_add),
    .add_sub         (add_sub),
    .shift_HQ_LQ_Q_1 (shift_HQ_LQ_Q_1),
    .A               (A),
    .B               (B),
    .Q_LSB           (Q_LSB),
    .z               (z),
    .Y               (Y),
    .Y_valid         (Y_valid)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // drive happens #1 after the edge, outputs are read there too
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // FSM-style iteration: inspect Q_LSB, optional add/sub, then shift
  task automatic iterate(input int iters);
    for (int i = 0; i < iters; i++) begin
      if (Q_LSB == BOOTH_ADD || Q_LSB == BOOTH_SUB) begin
        load_add = 1'b1;
        add_sub  = (Q_LSB == BOOTH_SUB) ? SUB : ADD;
        tick();
        load_add = 1'b0;
      end
      shift_HQ_LQ_Q_1 = 1'b1;
      tick();
      shift_HQ_LQ_Q_1 = 1'b0;
    end
  endtask

  task automatic load(input logic [N-1:0] a, input logic [N-1:0] b);
    A = a; B = b; load_A = 1'b1; load_B = 1'b1;
    tick();
    load_A = 1'b0; load_B = 1'b0;
  endtask

  task automatic mult(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic [2*N-1:0] exp);
    load(a, b);
    chk({tag, "_z_after_load"}, 64'(z), 64'(0));
    iterate(N - 1);
    chk({tag, "_z_before_last"}, 64'(z), 64'(0));
    chk({tag, "_vld_before_last"}, 64'(Y_valid), 64'(0));
    iterate(1);
    chk({tag, "_y"}, 64'(Y), 64'(exp));
    chk({tag, "_vld"}, 64'(Y_valid), 64'(1));
    chk({tag, "_z"}, 64'(z), 64'(1));
  endtask

  initial begin
    // reset state, observed before any clock edge
    #1;
    chk("rst_y", 64'(Y), 64'(0));
    chk("rst_vld", 64'(Y_valid), 64'(0));
    chk("rst_z", 64'(z), 64'(1));
    chk("rst_qlsb", 64'(Q_LSB), 64'(BOOTH_NOP0));
    tick();
    rst = 1'b1;
    tick();

    // main function
    mult("p3x5", 8'd3, 8'd5, 16'h000F);
    mult("pm3x5", 8'hFD, 8'd5, 16'hFFF1);
    mult("p5xm3", 8'd5, 8'hFD, 16'hFFF1);
    mult("pm128sq", 8'h80, 8'h80, 16'h4000);
    mult("p127xm128", 8'h7F, 8'h80, 16'hC080);

    // extra shift after completion: counter holds at zero, valid sticks
    shift_HQ_LQ_Q_1 = 1'b1;
    tick();
    shift_HQ_LQ_Q_1 = 1'b0;
    chk("extra_shift_z", 64'(z), 64'(1));
    chk("extra_shift_vld", 64'(Y_valid), 64'(1));
    // load_A alone leaves valid untouched
    A = 8'h11; load_A = 1'b1;
    tick();
    load_A = 1'b0;
    chk("loadA_vld", 64'(Y_valid), 64'(1));

    // load_B wins over a simultaneous shift
    B = 8'h01; load_B = 1'b1; shift_HQ_LQ_Q_1 = 1'b1;
    tick();
    load_B = 1'b0; shift_HQ_LQ_Q_1 = 1'b0;
    chk("prio_y", 64'(Y), 64'(16'h0001));
    chk("prio_qlsb", 64'(Q_LSB), 64'(BOOTH_SUB));
    chk("prio_z", 64'(z), 64'(0));
    chk("prio_vld_cleared", 64'(Y_valid), 64'(0));
    // counter was loaded with N: exactly N shifts bring z back
    iterate(N - 1);
    chk("prio_cnt_z7", 64'(z), 64'(0));
    iterate(1);
    chk("prio_cnt_z8", 64'(z), 64'(1));
    chk("prio_done_vld", 64'(Y_valid), 64'(1));

    // load_add wins over a simultaneous shift: M=0x11, HQ 0 -> 0x011 (+M)
    A = 8'h11; B = 8'h00; load_A = 1'b1; load_B = 1'b1;
    tick();
    load_A = 1'b0; load_B = 1'b0;
    load_add = 1'b1; add_sub = ADD; shift_HQ_LQ_Q_1 = 1'b1;
    tick();
    load_add = 1'b0; shift_HQ_LQ_Q_1 = 1'b0;
    chk("add_prio_y", 64'(Y), 64'(16'h1100));
    chk("add_prio_qlsb", 64'(Q_LSB), 64'(BOOTH_NOP0));
    load_add = 1'b1; add_sub = SUB;
    tick();
    tick();
    load_add = 1'b0;
    chk("sub_twice_y", 64'(Y), 64'(16'hEF00));

    // asynchronous reset mid-run, checked away from any clock edge
    load(8'd3, 8'd5);
    iterate(3);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_y", 64'(Y), 64'(0));
    chk("midrst_vld", 64'(Y_valid), 64'(0));
    chk("midrst_z", 64'(z), 64'(1));
    chk("midrst_qlsb", 64'(Q_LSB), 64'(BOOTH_NOP0));
    tick();
    rst = 1'b1;
    tick();
    mult("post_rst", 8'd3, 8'd5, 16'h000F);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/module_booth_datapath.md
Name: module_booth_datapath

Overview:
- Radix-2 Booth multiplier datapath, directly downstream of the Booth control FSM.
- Consumes the FSM strobes load_A, load_B, load_add, add_sub and shift_HQ_LQ_Q_1.
- Returns the FSM decision inputs Q_LSB and z.
- Holds the multiplicand, accumulator, multiplier and iteration counter, and presents the signed 2N-bit product with a registered valid flag.

Parameters:
- N, 8, operand width in bits (signed two's complement); must be ≥2.
- CW, $clog2(N)+1, iteration counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset. One clock; reset is asynchronous and active-low.
- load_A  in  1  capture multiplicand A into M.
- load_B  in  1  capture multiplier B into LQ; clear HQ, Q_1 and valid; counter=N.
- load_add  in  1  update accumulator HQ with ±M.
- add_sub  in  1  0: HQ+M, 1: HQ−M. Sampled only with load_add.
- shift_HQ_LQ_Q_1  in  1  arithmetic right shift of {HQ,LQ,Q_1}; counter decrement.
- A  in  N  multiplicand, signed.
- B  in  N  multiplier, signed.
- Q_LSB  out  2  {LQ[0], Q_1}, combinational from registers.
- z  out  1  1 when counter==0, combinational from register.
- Y  out  2N  product {HQ[N-1:0], LQ}.
- Y_valid  out  1  registered; product complete.

Behaviour:
- Registers:
  - M: N bits.
  - HQ: N+1 bits (guard bit, so −2^(N−1) operands cannot overflow).
  - LQ: N bits.
  - Q_1: 1 bit.
  - cnt: CW bits.
  - Y_valid: 1 bit.
- Reset (rst=0, asynchronous): all registers 0. Hence Q_LSB=2'b00, z=1, Y=0, Y_valid=0.
- All register updates take effect at the rising edge after the strobe is sampled high. Strobes are level-sampled every cycle.
- load_A: M<=A. Independent of the other strobes; may coincide with any of them.
- Priority among the HQ/LQ/Q_1/cnt group is load_B > load_add > shift_HQ_LQ_Q_1. The lower-priority strobe is ignored that cycle, with no deferred action.
- load_B: LQ<=B, HQ<=0, Q_1<=0, cnt<=N, Y_valid<=0.
- load_add:
  - HQ <= HQ + sext(M) when add_sub=0.
  - HQ <= HQ − sext(M) when add_sub=1.
  - Arithmetic is modulo 2^(N+1). LQ, Q_1 and cnt are unchanged.
- shift_HQ_LQ_Q_1:
  - {HQ,LQ,Q_1} <= {HQ[N], HQ, LQ} (arithmetic shift right by 1; HQ MSB replicated).
  - If cnt≠0: cnt<=cnt−1. If cnt==0: cnt holds (no wrap).
  - Y_valid<=1 when cnt==1 before the shift.
- Y_valid:
  - Stays 1 until the next load_B or reset. Unaffected by load_A or load_add.
  - Y is meaningful only while Y_valid=1.
- z: asserted immediately after reset and after N shifts. Deasserted one cycle after load_B (cnt=N).
- Q_LSB encoding: 01 means add M, 10 means subtract M, 00/11 means no operation. The datapath does not enforce this; it executes whatever strobes arrive.
- Latency for one product: 1 load cycle, then N iterations of (optional add/sub + shift). Y is stable one cycle after the final shift.
- Reset mid-operation: registers clear immediately. The current product is lost and Y_valid=0.
- Product range: signed 2N bits. (−2^(N−1))² = 2^(2N−2) fits.

Decomposition:
- Package booth_pkg:
  - Default N.
  - CW derivation.
  - Localparams for the Q_LSB codes: BOOTH_NOP0=2'b00, BOOTH_ADD=2'b01, BOOTH_SUB=2'b10, BOOTH_NOP1=2'b11.
  - add_sub encodings: ADD=0, SUB=1.
- One natural sub-module, module_booth_addsub: combinational (N+1)-bit adder/subtractor, inputs HQ, M, add_sub, output sum. The register file, shifter and counter stay in the top module.

Test Plan (N=8; model each iteration as the FSM does: check Q_LSB, optional load_add, then shift):
1. Reset low mid-run, then release → Y=0, Y_valid=0, z=1, Q_LSB=00 immediately, without waiting for clk.
2. A=3, B=5, load_A+load_B same cycle, 8 iterations → z=1 and Y_valid=1 after the 8th shift, Y=16'h000F.
3. A=−3 (8'hFD), B=5 → Y=16'hFFF1 (−15); A=5, B=−3 → Y=16'hFFF1.
4. A=−128, B=−128 → Y=16'h4000 (16384), which checks the guard bit; A=127, B=−128 → Y=16'hC080 (−16256).
5. load_B and shift_HQ_LQ_Q_1 in the same cycle with B=8'h01 → LQ=8'h01, cnt=8, Q_LSB=2'b10; the shift is ignored.
6. Extra shift after z=1 → cnt stays 0, no wrap, z stays 1, Y_valid stays 1; a subsequent load_B clears Y_valid.
